step_sequencer: RTL

Multi-cycle control sequencer for the cirno CPU datapath. It replaces the ad-hoc step counter in the top level with a single registered Moore state machine. Each instruction is walked through fetch, decode, operand fetch, ALU, memory and result-store phases according to the decoder's `inst_type`, and exactly one datapath enable is driven per cycle. Instruction retirement and halt are reported to the top level.

---
 rtl/step_sequencer.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/step_sequencer.sv
// Multi-cycle Moore control sequencer for the cirno CPU datapath.
// Optional performance counters are built when SEQ_PERF_CNT_EN is defined.
module step_sequencer #(
  parameter int unsigned MEM_RD_WAIT = 0
) (
  input  logic        clk,
  input  logic        init_n,
  input  logic        start,
  input  logic [2:0]  inst_type,
  input  logic        halt,
  output logic        fetch_unit_en,
  output logic        decoder_en,
  output logic        reg_r_en,
  output logic        alu_en,
  output logic        memory_w_en,
  output logic        memory_r_en,
  output logic        reg_w_en,
  output logic        inst_retire,
  output logic        done,
  output logic        illegal_op,
  output logic [15:0] retire_cnt,
  output logic [15:0] cycle_cnt
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_OPER   = 4'd3,
    S_EXEC   = 4'd4,
    S_MEMW   = 4'd5,
    S_MEMR   = 4'd6,
    S_WB     = 4'd7,
    S_HALT   = 4'd8
  } state_t;

  localparam logic [2:0] WAIT_LOAD = 3'(MEM_RD_WAIT);

  state_t     state;
  state_t     state_next;
  logic [2:0] cur_type;
  logic [2:0] cur_type_next;
  logic [2:0] wait_cnt;
  logic [2:0] wait_next;
  logic       retire;
  logic       illegal_set;

  // State, latched instruction class and memory-read wait counter
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state    <= S_IDLE;
      cur_type <= 3'd0;
      wait_cnt <= 3'd0;
    end else begin
      state    <= state_next;
      cur_type <= cur_type_next;
      wait_cnt <= wait_next;
    end
  end

  // Next-state, retirement and illegal-class detection
  always_comb begin
    state_next    = state;
    cur_type_next = cur_type;
    wait_next     = wait_cnt;
    retire        = 1'b0;
    illegal_set   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_FETCH;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_FETCH: begin
        state_next = S_DECODE;
      end
      S_DECODE: begin
        cur_type_next = inst_type;
        if (halt) begin
          state_next = S_HALT;
        end else begin
          case (inst_type)
            3'd1, 3'd4, 3'd5, 3'd6: state_next = S_OPER;
            3'd3:                   state_next = S_WB;
            3'd2: begin
              state_next = S_FETCH;
              retire     = 1'b1;
            end
            default: begin
              // classes 0 and 7 retire as no-ops and flag the fault
              state_next  = S_FETCH;
              retire      = 1'b1;
              illegal_set = 1'b1;
            end
          endcase
        end
      end
      S_OPER: begin
        case (cur_type)
          3'd1: state_next = S_EXEC;
          3'd4: begin
            state_next = S_FETCH;
            retire     = 1'b1;
          end
          3'd5: state_next = S_MEMW;
          3'd6: begin
            state_next = S_MEMR;
            wait_next  = WAIT_LOAD;
          end
          default: state_next = S_FETCH;
        endcase
      end
      S_EXEC: begin
        state_next = S_WB;
      end
      S_MEMW: begin
        state_next = S_FETCH;
        retire     = 1'b1;
      end
      S_MEMR: begin
        if (wait_cnt == 3'd0) begin
          state_next = S_WB;
        end else begin
          wait_next = wait_cnt - 3'd1;
        end
      end
      S_WB: begin
        state_next = S_FETCH;
        retire     = 1'b1;
      end
      S_HALT: begin
        if (start) begin
          state_next = S_FETCH;
        end else begin
          state_next = S_HALT;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Datapath enables and done, registered from the next state so they track state exactly
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      fetch_unit_en <= 1'b0;
      decoder_en    <= 1'b0;
      reg_r_en      <= 1'b0;
      alu_en        <= 1'b0;
      memory_w_en   <= 1'b0;
      memory_r_en   <= 1'b0;
      reg_w_en      <= 1'b0;
      done          <= 1'b0;
    end else begin
      fetch_unit_en <= (state_next == S_FETCH);
      decoder_en    <= (state_next == S_DECODE);
      reg_r_en      <= (state_next == S_OPER);
      alu_en        <= (state_next == S_EXEC);
      memory_w_en   <= (state_next == S_MEMW);
      memory_r_en   <= (state_next == S_MEMR);
      reg_w_en      <= (state_next == S_WB);
      done          <= (state_next == S_HALT);
    end
  end

  // Sticky illegal-class flag, cleared only by reset
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      illegal_op <= 1'b0;
    end else if (illegal_set) begin
      illegal_op <= 1'b1;
    end else begin
      illegal_op <= illegal_op;
    end
  end

  // Retirement in DECODE depends on that cycle's decoder inputs, so it cannot be registered
  assign inst_retire = retire;

`ifdef SEQ_PERF_CNT_EN
  logic [15:0] retire_q;
  logic [15:0] cycle_q;
  logic        active;

  assign active = (state != S_IDLE) && (state != S_HALT);

  // Saturating retire and active-cycle counters; a fresh start from IDLE clears them
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      retire_q <= 16'd0;
      cycle_q  <= 16'd0;
    end else if ((state == S_IDLE) && start) begin
      retire_q <= 16'd0;
      cycle_q  <= 16'd0;
    end else begin
      if (retire && (retire_q != 16'hFFFF)) begin
        retire_q <= retire_q + 16'd1;
      end else begin
        retire_q <= retire_q;
      end
      if (active && (cycle_q != 16'hFFFF)) begin
        cycle_q <= cycle_q + 16'd1;
      end else begin
        cycle_q <= cycle_q;
      end
    end
  end

  assign retire_cnt = retire_q;
  assign cycle_cnt  = cycle_q;
`else
  assign retire_cnt = 16'd0;
  assign cycle_cnt  = 16'd0;
`endif

endmodule
